gb_register_file: RTL and testbench
===================================

Name: gb_register_file

Overview:
- Parametrised successor to the CPU register bank: 2*NUM_PAIRS byte registers, addressable as bytes or as 16-bit pairs.
- Adds native pair writes, a 16-bit increment/decrement unit (IDU) and a shadow bank with single-cycle swap.
- Flags write collisions in a sticky error bit.
- Sits between the CPU decoder/ALU and the bus sequencer; SP is exported continuously.

Parameters:
- DATA_W, 8, byte register width; a pair is 2*DATA_W bits.
- NUM_PAIRS, 5, number of pairs (BC DE HL SP WZ); byte registers = 2*NUM_PAIRS.
- SP_PAIR, 3, pair index of the stack pointer; SP is excluded from the shadow swap.
- SP_RESET, 16'hFFFE, SP value after reset; width 2*DATA_W.
- Derived localparams: RA_W = clog2(2*NUM_PAIRS), PA_W = clog2(NUM_PAIRS).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- wr_en  in  1  byte write strobe
- wr_sel  in  RA_W  byte register index
- wr_data  in  DATA_W  byte write data
- pair_wr_en  in  1  pair write strobe
- pair_wr_sel  in  PA_W  pair index for pair write
- pair_wr_data  in  2*DATA_W  pair write data
- idu_en  in  1  IDU operation strobe
- idu_sel  in  PA_W  pair operated on by IDU
- idu_dec  in  1  0 = +1, 1 = -1
- bank_swap  in  1  exchange active and shadow banks
- err_clr  in  1  clear err_conflict
- rd_sel_a  in  RA_W  byte read port A select
- rd_data_a  out  DATA_W  byte read port A data
- rd_sel_b  in  RA_W  byte read port B select
- rd_data_b  out  DATA_W  byte read port B data
- pair_rd_sel  in  PA_W  pair read select
- pair_rd_data  out  2*DATA_W  pair read data
- sp_out  out  2*DATA_W  current SP
- idu_wrap  out  1  registered pulse: last IDU op wrapped
- err_conflict  out  1  sticky collision flag

Behaviour:
- Layout: byte 2p is the high byte and byte 2p+1 the low byte of pair p; pair value = {reg[2p], reg[2p+1]}.
- Reset (reset=0 at posedge clk):
  - All active and shadow bytes = 0, except active SP = SP_RESET.
  - idu_wrap = 0, err_conflict = 0.
  - Reset overrides every other input.
- Reads are combinational from the current active bank, so a write is visible the cycle after its clock edge.
- Out-of-range read selects return 0; out-of-range write/IDU selects are ignored and have no side effects.
- Byte write: reg[wr_sel] <= wr_data.
- Pair write: both bytes of pair pair_wr_sel are updated in the same cycle.
- IDU: pair[idu_sel] <= pair[idu_sel] ± 1 modulo 2^(2*DATA_W); the carry/borrow propagates from the low byte to the high byte.
  - idu_wrap goes to 1 for exactly one cycle after the edge on which FFFF→0000 (inc) or 0000→FFFF (dec) occurs; otherwise it is 0.
- Same-cycle collisions on one pair (a byte write counts for the pair containing it):
  - Priority is pair write > IDU > byte write.
  - Losers are dropped and err_conflict <= 1.
  - Writers targeting different pairs all commit with no error.
- bank_swap:
  - In one cycle, every pair except SP_PAIR exchanges active and shadow contents.
  - All writes and IDU ops in that cycle are dropped; if any strobe was asserted, err_conflict <= 1 and idu_wrap = 0.
  - A second swap restores the original contents.
- err_conflict:
  - Sticky; cleared only by err_clr or reset.
  - If err_clr and a new collision occur in the same cycle, the flag ends at 1 (set wins).
- sp_out always reflects active SP_PAIR and is unaffected by swaps.

Decomposition:
- Shared package gb_cpu_pkg holds:
  - Pair index constants PAIR_BC=0, PAIR_DE=1, PAIR_HL=2, PAIR_SP=3, PAIR_WZ=4.
  - Byte index constants REG_B..REG_Z.
  - IDU op encoding.
- One sub-module, gb_idu16: combinational 16-bit ±1 with a wrap output, reused later by the PC unit.

Test Plan:
- Reset with reset=0 for 2 cycles → every byte reads 0, sp_out=16'hFFFE, err_conflict=0, idu_wrap=0.
- Pair write BC=16'h1234, then read → rd_sel_a=B gives 8'h12, rd_sel_b=C gives 8'h34, pair_rd BC=16'h1234.
- HL=16'hFFFF, idu_en inc on HL → HL=16'h0000 and idu_wrap=1 for one cycle; then dec → HL=16'hFFFF and idu_wrap pulses again.
- Same cycle: pair write DE=16'hAAAA, IDU inc DE, byte write E=8'h55 → DE=16'hAAAA and err_conflict=1; err_clr → 0 the next cycle.
- Write BC=16'h0102 and SP=16'hC000, bank_swap → BC=0 and SP=16'hC000; write BC=16'h0304, swap → BC=16'h0102; swap → BC=16'h0304.
- Assert reset mid-IDU and during a pair write → reset values win, no wrap pulse, err_conflict=0.

Source files
------------

// File: rtl/gb_cpu_pkg.sv
// gb_cpu_pkg: shared CPU register indices and IDU op encoding.
package gb_cpu_pkg;
   localparam int PAIR_BC = 0;
   localparam int PAIR_DE = 1;
   localparam int PAIR_HL = 2;
   localparam int PAIR_SP = 3;
   localparam int PAIR_WZ = 4;
   localparam int REG_B = 0;
   localparam int REG_C = 1;
   localparam int REG_D = 2;
   localparam int REG_E = 3;
   localparam int REG_H = 4;
   localparam int REG_L = 5;
   localparam int REG_S = 6;
   localparam int REG_P = 7;
   localparam int REG_W = 8;
   localparam int REG_Z = 9;
   typedef enum logic {IDU_INC = 1'b0, IDU_DEC = 1'b1} idu_op_e;
endpackage

// File: rtl/gb_idu16.sv
// gb_idu16: combinational +/-1 on a register pair with wrap detect.
module gb_idu16
   import gb_cpu_pkg::*;
#(
   parameter int W = 16
)(
   input  logic [W-1:0] i_val,
   input  idu_op_e      i_op,
   output logic [W-1:0] o_val,
   output logic         o_wrap
);
   assign o_val  = (i_op == IDU_DEC) ? i_val - 1'b1 : i_val + 1'b1;
   assign o_wrap = (i_op == IDU_DEC) ? ~|i_val : &i_val;
endmodule

// File: rtl/gb_register_file.sv
// gb_register_file: byte/pair CPU register bank with IDU, shadow bank swap and collision flag.
module gb_register_file
   import gb_cpu_pkg::*;
#(
   parameter int                 DATA_W    = 8,
   parameter int                 NUM_PAIRS = 5,
   parameter int                 SP_PAIR   = PAIR_SP,
   parameter logic [2*DATA_W-1:0] SP_RESET = 16'hFFFE,
   localparam int                RA_W      = $clog2(2*NUM_PAIRS),
   localparam int                PA_W      = $clog2(NUM_PAIRS)
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [RA_W-1:0]     wr_sel,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                pair_wr_en,
   input  logic [PA_W-1:0]     pair_wr_sel,
   input  logic [2*DATA_W-1:0] pair_wr_data,
   input  logic                idu_en,
   input  logic [PA_W-1:0]     idu_sel,
   input  logic                idu_dec,
   input  logic                bank_swap,
   input  logic                err_clr,
   input  logic [RA_W-1:0]     rd_sel_a,
   output logic [DATA_W-1:0]   rd_data_a,
   input  logic [RA_W-1:0]     rd_sel_b,
   output logic [DATA_W-1:0]   rd_data_b,
   input  logic [PA_W-1:0]     pair_rd_sel,
   output logic [2*DATA_W-1:0] pair_rd_data,
   output logic [2*DATA_W-1:0] sp_out,
   output logic                idu_wrap,
   output logic                err_conflict
);
   localparam int              NB     = 2*NUM_PAIRS;
   localparam logic [PA_W:0]   NP_L   = (PA_W+1)'(NUM_PAIRS);
   localparam logic [RA_W:0]   NB_L   = (RA_W+1)'(NB);
   localparam logic [PA_W-1:0] SP_SEL = PA_W'(SP_PAIR);

   logic [DATA_W-1:0]   r_act [NB];
   logic [DATA_W-1:0]   r_shd [NB];
   logic                r_wrap;
   logic                r_err;
   logic [2*DATA_W-1:0] w_pair [NUM_PAIRS];
   logic                w_pw_ok, w_idu_ok, w_bw_ok;
   logic                w_pw_go, w_idu_go, w_bw_go;
   logic                w_err_set, w_idu_wrap;
   logic [PA_W-1:0]     w_bw_pair;
   logic [2*DATA_W-1:0] w_idu_in, w_idu_out;

   always_comb
      for (int p = 0; p < NUM_PAIRS; p++)
         w_pair[PA_W'(p)] = {r_act[RA_W'(2*p)], r_act[RA_W'(2*p+1)]};

   assign w_pw_ok   = pair_wr_en && ({1'b0, pair_wr_sel} < NP_L);
   assign w_idu_ok  = idu_en && ({1'b0, idu_sel} < NP_L);
   assign w_bw_ok   = wr_en && ({1'b0, wr_sel} < NB_L);
   assign w_bw_pair = wr_sel[RA_W-1:1];

   // Priority on a shared pair: pair write > IDU > byte write; a swap drops everything.
   assign w_pw_go   = w_pw_ok && !bank_swap;
   assign w_idu_go  = w_idu_ok && !bank_swap && !(w_pw_ok && idu_sel == pair_wr_sel);
   assign w_bw_go   = w_bw_ok && !bank_swap && !(w_pw_ok && w_bw_pair == pair_wr_sel)
                      && !(w_idu_ok && w_bw_pair == idu_sel);
   assign w_err_set = bank_swap ? (w_pw_ok || w_idu_ok || w_bw_ok)
                                : ((w_idu_ok && !w_idu_go) || (w_bw_ok && !w_bw_go));
   assign w_idu_in  = w_idu_ok ? w_pair[idu_sel] : '0;

   gb_idu16 #(.W(2*DATA_W)) u_idu (
      .i_val  (w_idu_in),
      .i_op   (idu_op_e'(idu_dec)),
      .o_val  (w_idu_out),
      .o_wrap (w_idu_wrap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NB; i++) begin
            r_act[RA_W'(i)] <= '0;
            r_shd[RA_W'(i)] <= '0;
         end
         r_act[{SP_SEL, 1'b0}] <= SP_RESET[2*DATA_W-1:DATA_W];
         r_act[{SP_SEL, 1'b1}] <= SP_RESET[DATA_W-1:0];
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_wrap <= w_idu_go && w_idu_wrap;
         r_err  <= w_err_set || (r_err && !err_clr);
         if (bank_swap) begin
            for (int p = 0; p < NUM_PAIRS; p++)
               if (p != SP_PAIR) begin
                  r_act[RA_W'(2*p)]   <= r_shd[RA_W'(2*p)];
                  r_act[RA_W'(2*p+1)] <= r_shd[RA_W'(2*p+1)];
                  r_shd[RA_W'(2*p)]   <= r_act[RA_W'(2*p)];
                  r_shd[RA_W'(2*p+1)] <= r_act[RA_W'(2*p+1)];
               end
         end else begin
            if (w_bw_go)
               r_act[wr_sel] <= wr_data;
            if (w_idu_go)
               {r_act[{idu_sel, 1'b0}], r_act[{idu_sel, 1'b1}]} <= w_idu_out;
            if (w_pw_go)
               {r_act[{pair_wr_sel, 1'b0}], r_act[{pair_wr_sel, 1'b1}]} <= pair_wr_data;
         end
      end
   end

   assign rd_data_a    = ({1'b0, rd_sel_a} < NB_L) ? r_act[rd_sel_a] : '0;
   assign rd_data_b    = ({1'b0, rd_sel_b} < NB_L) ? r_act[rd_sel_b] : '0;
   assign pair_rd_data = ({1'b0, pair_rd_sel} < NP_L) ? w_pair[pair_rd_sel] : '0;
   assign sp_out       = w_pair[SP_SEL];
   assign idu_wrap     = r_wrap;
   assign err_conflict = r_err;
endmodule

// File: tb/tb_gb_register_file.sv
// tb_gb_register_file: vector table plus scoreboard queue for gb_register_file.
module tb_gb_register_file;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wr_en = 1'b0, pair_wr_en = 1'b0, idu_en = 1'b0, idu_dec = 1'b0;
   logic        bank_swap = 1'b0, err_clr = 1'b0;
   logic [3:0]  wr_sel = '0, rd_sel_a = '0, rd_sel_b = '0;
   logic [2:0]  pair_wr_sel = '0, idu_sel = '0, pair_rd_sel = '0;
   logic [7:0]  wr_data = '0, rd_data_a, rd_data_b;
   logic [15:0] pair_wr_data = '0, pair_rd_data, sp_out;
   logic        idu_wrap, err_conflict;
   int          n_chk = 0, n_fail = 0;

   typedef struct {
      logic rst; logic pw; logic [2:0] pws; logic [15:0] pwd;
      logic bw; logic [3:0] bws; logic [7:0] bwd;
      logic ie; logic [2:0] is; logic id; logic sw; logic ec;
      logic [2:0] prs; logic [15:0] e_pair; logic [15:0] e_sp; logic e_wrap; logic e_err;
   } vec_t;

   vec_t tbl [36];
   vec_t q [$];

   gb_register_file dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .pair_wr_en(pair_wr_en), .pair_wr_sel(pair_wr_sel), .pair_wr_data(pair_wr_data),
      .idu_en(idu_en), .idu_sel(idu_sel), .idu_dec(idu_dec), .bank_swap(bank_swap),
      .err_clr(err_clr), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a), .rd_sel_b(rd_sel_b),
      .rd_data_b(rd_data_b), .pair_rd_sel(pair_rd_sel), .pair_rd_data(pair_rd_data),
      .sp_out(sp_out), .idu_wrap(idu_wrap), .err_conflict(err_conflict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int idx, input vec_t v);
      vec_t e;
      @(negedge clk);
      reset = ~v.rst;
      pair_wr_en = v.pw; pair_wr_sel = v.pws; pair_wr_data = v.pwd;
      wr_en = v.bw; wr_sel = v.bws; wr_data = v.bwd;
      idu_en = v.ie; idu_sel = v.is; idu_dec = v.id;
      bank_swap = v.sw; err_clr = v.ec; pair_rd_sel = v.prs;
      q.push_back(v);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk($sformatf("v%0d pair", idx), pair_rd_data, e.e_pair);
      chk($sformatf("v%0d sp", idx), sp_out, e.e_sp);
      chk($sformatf("v%0d wrap", idx), {15'd0, idu_wrap}, {15'd0, e.e_wrap});
      chk($sformatf("v%0d err", idx), {15'd0, err_conflict}, {15'd0, e.e_err});
   endtask

   initial begin
      //        rst pw pws pwd        bw bws bwd   ie is id sw ec prs e_pair    e_sp       wr er
      tbl = '{
         '{1, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 0, 0},
         '{1, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 0, 0},
         '{0, 1, 0, 16'h1234, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h1234, 16'hFFFE, 0, 0},
         '{0, 1, 2, 16'hFFFF, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 16'hFFFF, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 2, 0, 0, 0, 2, 16'h0000, 16'hFFFE, 1, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 16'h0000, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 2, 1, 0, 0, 2, 16'hFFFF, 16'hFFFE, 1, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 2, 1, 0, 0, 2, 16'hFFFE, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 2, 0, 0, 0, 2, 16'hFFFF, 16'hFFFE, 0, 0},
         '{0, 1, 1, 16'hAAAA, 1, 3, 8'h55, 1, 1, 0, 0, 0, 1, 16'hAAAA, 16'hFFFE, 0, 1},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 16'hAAAA, 16'hFFFE, 0, 1},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 16'hAAAA, 16'hFFFE, 0, 0},
         '{0, 1, 4, 16'hBEEF, 1, 4, 8'h12, 1, 1, 0, 0, 0, 1, 16'hAAAB, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 16'h12FF, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4, 16'hBEEF, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 1, 2, 8'h00, 1, 1, 0, 0, 0, 1, 16'hAAAC, 16'hFFFE, 0, 1},
         '{0, 1, 0, 16'h1111, 1, 0, 8'h22, 0, 0, 0, 0, 1, 0, 16'h1111, 16'hFFFE, 0, 1},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h1111, 16'hFFFE, 0, 0},
         '{0, 1, 0, 16'h0102, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0102, 16'hFFFE, 0, 0},
         '{0, 1, 3, 16'hC000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 3, 16'hC000, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0000, 16'hC000, 0, 0},
         '{0, 1, 0, 16'h0304, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0304, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0102, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0304, 16'hC000, 0, 0},
         '{0, 1, 0, 16'h9999, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0102, 16'hC000, 0, 1},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 16'h12FF, 16'hC000, 0, 0},
         '{0, 1, 2, 16'hFFFF, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 16'hFFFF, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 1, 2, 0, 1, 0, 2, 16'h0000, 16'hC000, 0, 1},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 1, 2, 16'hFFFF, 16'hC000, 0, 0},
         '{0, 1, 5, 16'h1234, 1,12, 8'h77, 1, 7, 0, 0, 0, 5, 16'h0000, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 2, 16'hFFFF, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0102, 16'hC000, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4, 16'hBEEF, 16'hC000, 0, 0},
         '{1, 1, 0, 16'h5555, 1, 0, 8'h22, 1, 2, 0, 0, 0, 2, 16'h0000, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 0, 0},
         '{0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0000, 16'hFFFE, 0, 0}
      };
      for (int i = 0; i < 36; i++) begin
         step(i, tbl[i]);
         if (i == 1) begin
            // After reset only the SP bytes are nonzero.
            for (int b = 0; b < 10; b++) begin
               rd_sel_a = 4'(b);
               rd_sel_b = 4'(9 - b);
               #1;
               chk($sformatf("rst byte a%0d", b), {8'd0, rd_data_a},
                   (b == 6) ? 16'h00FF : (b == 7) ? 16'h00FE : 16'h0000);
               chk($sformatf("rst byte b%0d", 9 - b), {8'd0, rd_data_b},
                   (b == 3) ? 16'h00FF : (b == 2) ? 16'h00FE : 16'h0000);
            end
            rd_sel_a = 4'd12;
            #1;
            chk("oob byte read", {8'd0, rd_data_a}, 16'h0000);
         end
         if (i == 2) begin
            rd_sel_a = 4'd0;
            rd_sel_b = 4'd1;
            #1;
            chk("byte B", {8'd0, rd_data_a}, 16'h0012);
            chk("byte C", {8'd0, rd_data_b}, 16'h0034);
         end
         if (i == 9) begin
            rd_sel_b = 4'd3;
            #1;
            chk("byte E dropped", {8'd0, rd_data_b}, 16'h00AA);
         end
         if (i == 13) begin
            rd_sel_a = 4'd4;
            #1;
            chk("byte H written", {8'd0, rd_data_a}, 16'h0012);
         end
      end
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
